// File: rtl/sclkfifolut_rd2stream.sv
`default_nettype none
// ============================================================================
//  Module      : sclkfifolut_rd2stream
//  Description : Read-side drain for sclkfifolut. Issues the FIFO read
//                enable, absorbs the FIFO's one-cycle registered read latency
//                into a 3-entry in-order buffer and presents the words on a
//                valid/ready stream at up to one word per cycle.
//                fifo_ren depends only on local registers and fifo_rempty,
//                so there is no combinational path from out_ready.
//  Ports       : clk          clock, rising edge
//                srst         synchronous reset, active high
//                fifo_ren     read enable to FIFO
//                fifo_rdata   FIFO read data, valid 1 cycle after accepted ren
//                fifo_rempty  FIFO empty flag (registered in FIFO)
//                out_valid    stream word available
//                out_ready    consumer accepts word on out_valid & out_ready
//                out_data     stream data (buffer head)
//                out_count    delivered-word counter, wraps
//  Revision    : 1.0  initial release
// ============================================================================
module sclkfifolut_rd2stream #(
    parameter int FIFO_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    output logic                   fifo_ren,
    input  logic [FIFO_WIDTH-1:0]  fifo_rdata,
    input  logic                   fifo_rempty,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIFO_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    localparam logic [1:0] c_LAST_IDX = 2'd2;   // highest buffer index
    localparam logic [2:0] c_DEPTH    = 3'd3;   // buffer entries

    logic [FIFO_WIDTH-1:0]  r_mem [0:2];
    logic [1:0]             r_head;
    logic [1:0]             r_tail;
    logic [1:0]             r_occ;
    logic                   r_pend;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [2:0]             w_inflight;
    logic                   w_pop;
    logic [1:0]             w_head_nxt;
    logic [1:0]             w_tail_nxt;

    // Words already buffered plus the one still in the FIFO's read register.
    // Reserving a slot for the in-flight word keeps the landing from ever
    // overrunning the buffer, without looking at out_ready.
    assign w_inflight = {1'b0, r_occ} + {2'b00, r_pend};
    assign fifo_ren   = ~srst & ~fifo_rempty & (w_inflight < c_DEPTH);

    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_mem[r_head];
    assign out_count  = r_count;

    assign w_pop      = out_valid & out_ready;
    assign w_head_nxt = (r_head == c_LAST_IDX) ? 2'd0 : r_head + 2'd1;
    assign w_tail_nxt = (r_tail == c_LAST_IDX) ? 2'd0 : r_tail + 2'd1;

    always_ff @(posedge clk) begin
        if (srst) begin
            // Buffered and in-flight words are discarded; clearing r_pend
            // also drops any word landing from a read issued before reset.
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_occ   <= 2'd0;
            r_pend  <= 1'b0;
            r_count <= '0;
        end else begin
            r_pend <= fifo_ren;

            if (r_pend) begin
                r_mem[r_tail] <= fifo_rdata;
                r_tail        <= w_tail_nxt;
            end

            if (w_pop) begin
                r_head  <= w_head_nxt;
                r_count <= r_count + 1'b1;
            end

            // Simultaneous landing and pop leaves occupancy unchanged.
            case ({r_pend, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sclkfifolut_rd2stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sclkfifolut_rd2stream
//  Description : Directed self-checking bench for sclkfifolut_rd2stream.
//                Contains a small behavioural FIFO with registered empty flag
//                and one-cycle registered read data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sclkfifolut_rd2stream;

    logic        clk = 1'b0;
    logic        srst;
    logic        fifo_ren;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_rempty = 1'b1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;

    logic        tb_wr;
    logic [31:0] tb_wdata;
    logic        fifo_clr;

    logic [31:0] fmem [0:255];
    int          wp = 0;
    int          rp = 0;
    int          ren_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    int          snap;

    sclkfifolut_rd2stream #(
        .FIFO_WIDTH  (32),
        .COUNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .fifo_ren    (fifo_ren),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO feeding the DUT.
    always @(posedge clk) begin
        if (fifo_clr) begin
            wp          <= 0;
            rp          <= 0;
            fifo_rempty <= 1'b1;
        end else begin
            if (tb_wr) fmem[wp[7:0]] <= tb_wdata;
            if (fifo_ren) fifo_rdata <= fmem[rp[7:0]];
            wp          <= wp + (tb_wr ? 1 : 0);
            rp          <= rp + (fifo_ren ? 1 : 0);
            fifo_rempty <= ((wp + (tb_wr ? 1 : 0)) == (rp + (fifo_ren ? 1 : 0)));
        end
    end

    always @(posedge clk) begin
        if (fifo_ren) ren_cnt <= ren_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check("ren_while_empty", {31'd0, fifo_rempty & fifo_ren}, 32'd0);
    endtask

    initial begin
        // ---------------- T1 reset with data in FIFO ----------------
        srst      = 1'b1;
        out_ready = 1'b0;
        fifo_clr  = 1'b0;
        tb_wr     = 1'b1;
        tb_wdata  = 32'hAA;
        tick();
        tb_wr = 1'b0;
        check("t1_ren_a",   {31'd0, fifo_ren},  32'd0);
        check("t1_valid_a", {31'd0, out_valid}, 32'd0);
        check("t1_count_a", {16'd0, out_count}, 32'd0);
        check("t1_data_a",  out_data,           32'd0);
        tick();
        check("t1_ren_b",   {31'd0, fifo_ren},  32'd0);
        check("t1_valid_b", {31'd0, out_valid}, 32'd0);
        check("t1_count_b", {16'd0, out_count}, 32'd0);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        srst     = 1'b0;
        tick();
        check("t1_ren_idle",   {31'd0, fifo_ren},  32'd0);
        check("t1_valid_idle", {31'd0, out_valid}, 32'd0);

        // ---------------- T2 streaming, ready held high ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tb_wr    = 1'b1;
            tb_wdata = i;
            tick();
            if (i == 1) check("t2_ren_first", {31'd0, fifo_ren}, 32'd1);
            if (i <= 2) check("t2_valid_lat", {31'd0, out_valid}, 32'd0);
            if (i >= 3) begin
                check("t2_valid", {31'd0, out_valid}, 32'd1);
                check("t2_data",  out_data, i - 2);
            end
        end
        tb_wr = 1'b0;
        for (int k = 7; k <= 8; k++) begin
            tick();
            check("t2_valid_tail", {31'd0, out_valid}, 32'd1);
            check("t2_data_tail",  out_data, k);
        end
        tick();
        check("t2_valid_end", {31'd0, out_valid}, 32'd0);
        check("t2_count",     {16'd0, out_count}, 32'd8);

        // ---------------- T3 backpressure ----------------
        out_ready = 1'b0;
        snap      = ren_cnt;
        for (int i = 1; i <= 8; i++) begin
            tb_wr    = 1'b1;
            tb_wdata = i;
            tick();
        end
        tb_wr = 1'b0;
        check("t3_ren_pulses", ren_cnt - snap, 32'd3);
        check("t3_level",      wp - rp,        32'd5);
        check("t3_ren_off",    {31'd0, fifo_ren},  32'd0);
        check("t3_valid",      {31'd0, out_valid}, 32'd1);
        check("t3_data_hold",  out_data,           32'd1);
        tick();
        tick();
        check("t3_ren_pulses_hold", ren_cnt - snap, 32'd3);
        check("t3_data_hold2",      out_data,       32'd1);
        out_ready = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("t3_valid_drain", {31'd0, out_valid}, 32'd1);
            check("t3_data_drain",  out_data, k);
        end
        tick();
        check("t3_valid_end", {31'd0, out_valid}, 32'd0);
        check("t3_count",     {16'd0, out_count}, 32'd16);

        // ---------------- T4 toggled ready ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tb_wr    = 1'b1;
            tb_wdata = 32'h41 + i;
            tick();
        end
        tb_wr = 1'b0;
        for (int j = 0; j < 8; j++) begin
            out_ready = 1'b1;
            check("t4_valid", {31'd0, out_valid}, 32'd1);
            check("t4_data",  out_data, 32'h41 + j);
            tick();
            out_ready = 1'b0;
            if (j < 7) begin
                check("t4_data_stall", out_data, 32'h41 + j + 1);
                tick();
                check("t4_data_stable", out_data, 32'h41 + j + 1);
            end else begin
                check("t4_valid_empty", {31'd0, out_valid}, 32'd0);
                tick();
            end
        end
        check("t4_valid_end", {31'd0, out_valid}, 32'd0);
        check("t4_count",     {16'd0, out_count}, 32'd24);

        // ---------------- T5 trickle ----------------
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tb_wr    = 1'b1;
            tb_wdata = 32'h19;
            tick();
            tb_wr = 1'b0;
            check("t5_ren",        {31'd0, fifo_ren},  32'd1);
            check("t5_valid_n",    {31'd0, out_valid}, 32'd0);
            tick();
            check("t5_ren_off",    {31'd0, fifo_ren},  32'd0);
            check("t5_valid_n1",   {31'd0, out_valid}, 32'd0);
            tick();
            check("t5_valid_n2",   {31'd0, out_valid}, 32'd1);
            check("t5_data",       out_data,           32'h19);
            tick();
            check("t5_valid_n3",   {31'd0, out_valid}, 32'd0);
            tick();
            check("t5_valid_idle", {31'd0, out_valid}, 32'd0);
        end
        check("t5_count", {16'd0, out_count}, 32'd27);

        // ---------------- T6 reset mid-stream ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_wr    = 1'b1;
            tb_wdata = 32'h51 + i;
            tick();
        end
        tb_wr = 1'b0;
        // Buffer holds two words and a third is in flight.
        check("t6_valid_pre", {31'd0, out_valid}, 32'd1);
        check("t6_data_pre",  out_data,           32'h51);
        check("t6_ren_full",  {31'd0, fifo_ren},  32'd0);
        srst     = 1'b1;
        fifo_clr = 1'b1;
        tick();
        srst     = 1'b0;
        fifo_clr = 1'b0;
        check("t6_valid_rst", {31'd0, out_valid}, 32'd0);
        check("t6_count_rst", {16'd0, out_count}, 32'd0);
        check("t6_data_rst",  out_data,           32'd0);
        tick();
        check("t6_valid_post", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tb_wr     = 1'b1;
        tb_wdata  = 32'h1E;
        tick();
        tb_wdata  = 32'h1F;
        tick();
        tb_wr = 1'b0;
        tick();
        check("t6_valid_1e", {31'd0, out_valid}, 32'd1);
        check("t6_data_1e",  out_data,           32'h1E);
        tick();
        check("t6_valid_1f", {31'd0, out_valid}, 32'd1);
        check("t6_data_1f",  out_data,           32'h1F);
        tick();
        check("t6_valid_end", {31'd0, out_valid}, 32'd0);
        check("t6_count",     {16'd0, out_count}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
